// File: rtl/shift_right_iterative_32bits_if.sv
// Request/result bundle for the iterative right shifter.
// The master side issues start/operand/flush and observes the handshake
// and result; the slave side is the shifter itself.
interface shift_right_iterative_32bits_if #(
   parameter int WIDTH      = 32,
   parameter int SHAMT_BITS = 5
);
   logic                  start;
   logic                  arithmetic;
   logic [SHAMT_BITS-1:0] shamt;
   logic [WIDTH-1:0]      input0;
   logic                  flush;
   logic                  ready;
   logic                  busy;
   logic                  done;
   logic [WIDTH-1:0]      output0;

   modport master (
      output start, arithmetic, shamt, input0, flush,
      input  ready, busy, done, output0
   );

   modport slave (
      input  start, arithmetic, shamt, input0, flush,
      output ready, busy, done, output0
   );
endinterface

// File: rtl/shift_right_iterative_32bits.sv
// Multi-cycle 32-bit right shifter (SRL/SRA/SRLV/SRAV) for the EX stage.
// A request is accepted while ready=1; the operand is then shifted one bit
// per cycle, filling with the captured sign bit (SRA) or zero (SRL).
// busy stalls the pipeline from the accept cycle until the result lands;
// done pulses for one cycle when output0 holds the new result.
// Optional build macro: SHIFTER_FAST4_EN -- while at least four shifts
// remain, each cycle shifts by four, shortening worst-case latency to 11.
module shift_right_iterative_32bits #(
   parameter int WIDTH      = 32,
   parameter int SHAMT_BITS = 5
) (
   input logic                           clock,
   input logic                           nReset,
   shift_right_iterative_32bits_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [SHAMT_BITS-1:0] ONE  = SHAMT_BITS'(1);
`ifdef SHIFTER_FAST4_EN
   localparam logic [SHAMT_BITS-1:0] FOUR = SHAMT_BITS'(4);
`endif

   state_t                state, state_nxt;
   logic [WIDTH-1:0]      work, work_nxt;
   logic [SHAMT_BITS-1:0] count, count_nxt;
   logic                  fill, fill_nxt;
   logic [WIDTH-1:0]      result;
   logic                  load_out;
   logic                  accept;
   logic                  ready_int;

   // Single-bit step: drop the LSB, insert the captured fill at the top.
   function automatic logic [WIDTH-1:0] shr1(input logic [WIDTH-1:0] v,
                                             input logic             f);
      return {f, v[WIDTH-1:1]};
   endfunction

`ifdef SHIFTER_FAST4_EN
   // Four-bit step: the fill is replicated into the four vacated MSBs.
   function automatic logic [WIDTH-1:0] shr4(input logic [WIDTH-1:0] v,
                                             input logic             f);
      return {{4{f}}, v[WIDTH-1:4]};
   endfunction
`endif

   assign ready_int = (state == S_IDLE) || (state == S_DONE);
   // A flush in the same cycle wins over a new request.
   assign accept    = bus.start && ready_int && !bus.flush;

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, next-datapath and result-load decisions.
   always_comb begin
      state_nxt = state;
      work_nxt  = work;
      count_nxt = count;
      fill_nxt  = fill;
      load_out  = 1'b0;

      unique case (state)
         S_IDLE, S_DONE: begin
            if (accept) begin
               // Operand, amount and fill are all captured here so later
               // changes on the inputs cannot disturb the operation.
               work_nxt  = bus.input0;
               count_nxt = bus.shamt;
               fill_nxt  = bus.arithmetic & bus.input0[WIDTH-1];
               if (bus.shamt != '0) begin
                  state_nxt = S_SHIFT;
               end else begin
                  state_nxt = S_DONE;
                  load_out  = 1'b1;
               end
            end else if (state == S_DONE) begin
               state_nxt = S_IDLE;
            end
         end

         S_SHIFT: begin
`ifdef SHIFTER_FAST4_EN
            if (count >= FOUR) begin
               work_nxt  = shr4(work, fill);
               count_nxt = count - FOUR;
            end else begin
               work_nxt  = shr1(work, fill);
               count_nxt = count - ONE;
            end
`else
            work_nxt  = shr1(work, fill);
            count_nxt = count - ONE;
`endif
            // Final step: the result is captured on the way into DONE.
            if (count_nxt == '0) begin
               state_nxt = S_DONE;
               load_out  = 1'b1;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // Flush aborts from any state; the last completed result survives.
      if (bus.flush) begin
         state_nxt = S_IDLE;
         work_nxt  = '0;
         count_nxt = '0;
         fill_nxt  = 1'b0;
         load_out  = 1'b0;
      end
   end

   // Working operand, remaining count and captured fill bit.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         work  <= '0;
         count <= '0;
         fill  <= 1'b0;
      end else begin
         work  <= work_nxt;
         count <= count_nxt;
         fill  <= fill_nxt;
      end
   end

   // Result register; changes only when a completed shift enters DONE.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         result <= '0;
      end else if (load_out) begin
         result <= work_nxt;
      end
   end

   assign bus.ready   = ready_int;
   assign bus.busy    = (state == S_SHIFT) || accept;
   assign bus.done    = (state == S_DONE) && !bus.flush;
   assign bus.output0 = result;

endmodule
